// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing defaults, mode field layout and mode-update actions
package vga_pkg;

    localparam int DEF_H_VIS  = 640;
    localparam int DEF_H_FP   = 16;
    localparam int DEF_H_SYNC = 96;
    localparam int DEF_H_BP   = 48;
    localparam int DEF_V_VIS  = 480;
    localparam int DEF_V_FP   = 10;
    localparam int DEF_V_SYNC = 2;
    localparam int DEF_V_BP   = 33;

    localparam int MODE_AUTO_BIT = 7;
    localparam int MODE_PAT_LSB  = 0;
    localparam int MODE_PAT_W    = 3;

    typedef enum logic [1:0] {
        ACT_HOLD,
        ACT_LOAD,
        ACT_COUNT,
        ACT_STEP
    } mode_act_e;

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchroniser for asynchronous input pins
module sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/vga_frame_sequencer.sv
// rtl/vga_frame_sequencer.sv - VGA raster timing, frame counter and frame-aligned pattern-mode register
module vga_frame_sequencer
    import vga_pkg::*;
#(
    parameter int   H_VIS       = DEF_H_VIS,
    parameter int   H_FP        = DEF_H_FP,
    parameter int   H_SYNC      = DEF_H_SYNC,
    parameter int   H_BP        = DEF_H_BP,
    parameter int   V_VIS       = DEF_V_VIS,
    parameter int   V_FP        = DEF_V_FP,
    parameter int   V_SYNC      = DEF_V_SYNC,
    parameter int   V_BP        = DEF_V_BP,
    parameter logic SYNC_ACTIVE = 1'b0,
    parameter int   AUTO_FRAMES = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] mode_in,
    output logic       hsync,
    output logic       vsync,
    output logic       hblank,
    output logic       vblank,
    output logic       visible,
    output logic [9:0] hpos,
    output logic [9:0] vpos,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame,
    output logic [7:0] mode
);

    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_L = 10'(H_VIS);
    localparam logic [9:0] V_VIS_L = 10'(V_VIS);
    localparam logic [9:0] V_PRE = 10'(V_VIS - 1);
    localparam logic [9:0] HS_BEG = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_END = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_END = 10'(V_VIS + V_FP + V_SYNC);
    localparam logic [7:0] AUTO_LAST = 8'(AUTO_FRAMES - 1);

    logic [7:0] msync;
    logic [7:0] auto_cnt;
    logic [7:0] mode_n;
    logic [7:0] cnt_n;
    logic       h_wrap;
    logic       v_wrap;
    logic       vblank_edge;
    mode_act_e  act;

    sync2 #(.W(8)) u_mode_sync (
        .clk   (clk),
        .reset (reset),
        .d     (mode_in),
        .q     (msync)
    );

    assign h_wrap      = (hpos == H_LAST);
    assign v_wrap      = (vpos == V_LAST);
    assign vblank_edge = h_wrap && (vpos == V_PRE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hpos  <= '0;
            vpos  <= '0;
            frame <= '0;
        end else if (h_wrap) begin
            hpos <= '0;
            if (v_wrap) begin
                vpos  <= '0;
                frame <= frame + 8'd1;
            end else begin
                vpos <= vpos + 10'd1;
            end
        end else begin
            hpos <= hpos + 10'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode     <= '0;
            auto_cnt <= '0;
        end else begin
            mode     <= mode_n;
            auto_cnt <= cnt_n;
        end
    end

    // Mode only moves at the vblank edge so a pattern never changes mid-frame;
    // in auto mode the pattern field is kept from the register, not the pins.
    always_comb begin
        act    = ACT_HOLD;
        mode_n = mode;
        cnt_n  = auto_cnt;
        if (vblank_edge) begin
            if (!msync[MODE_AUTO_BIT])
                act = ACT_LOAD;
            else if (auto_cnt == AUTO_LAST)
                act = ACT_STEP;
            else
                act = ACT_COUNT;
        end
        case (act)
            ACT_LOAD: begin
                mode_n = msync;
                cnt_n  = '0;
            end
            ACT_STEP: begin
                mode_n = msync;
                mode_n[MODE_PAT_LSB +: MODE_PAT_W] = mode[MODE_PAT_LSB +: MODE_PAT_W] + MODE_PAT_W'(1);
                cnt_n  = '0;
            end
            ACT_COUNT: begin
                mode_n = msync;
                mode_n[MODE_PAT_LSB +: MODE_PAT_W] = mode[MODE_PAT_LSB +: MODE_PAT_W];
                cnt_n  = auto_cnt + 8'd1;
            end
            default: ;
        endcase
    end

    assign hblank      = (hpos >= H_VIS_L);
    assign vblank      = (vpos >= V_VIS_L);
    assign visible     = ~hblank & ~vblank;
    assign line_start  = (hpos == 10'd0);
    assign frame_start = line_start && (vpos == 10'd0);
    assign hsync       = (hpos >= HS_BEG && hpos < HS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    assign vsync       = (vpos >= VS_BEG && vpos < VS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;

endmodule

// File: tb/tb_vga_frame_sequencer.sv
// tb/tb_vga_frame_sequencer.sv - self-checking bench for vga_frame_sequencer on a small raster
module tb_vga_frame_sequencer;

    localparam int HV = 8, HF = 2, HS = 2, HB = 2;
    localparam int VV = 4, VF = 1, VS = 1, VB = 1;
    localparam int AF = 2;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FT = HT * VT;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] mode_in = 8'h00;
    logic       hsync, vsync, hblank, vblank, visible, line_start, frame_start;
    logic [9:0] hpos, vpos;
    logic [7:0] frame, mode;

    int total = 0;
    int bad = 0;
    bit cmp_en = 1'b0;

    int         m_t;
    logic [7:0] m_mode;
    logic [7:0] m_cnt;
    logic [7:0] hist [4];

    always #5 clk = ~clk;

    vga_frame_sequencer #(
        .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_ACTIVE(1'b0), .AUTO_FRAMES(AF)
    ) dut (
        .clk(clk), .reset(reset), .mode_in(mode_in),
        .hsync(hsync), .vsync(vsync), .hblank(hblank), .vblank(vblank),
        .visible(visible), .hpos(hpos), .vpos(vpos),
        .line_start(line_start), .frame_start(frame_start),
        .frame(frame), .mode(mode)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad < 40)
                $display("FAIL %s t=%0d got=%0h want=%0h", name, m_t, act, exp);
        end
    endtask

    function automatic bit is_vbl_edge(input int n);
        return (n % HT == 0) && ((n / HT) % VT == VV);
    endfunction

    function automatic logic [15:0] next_mode(input logic [7:0] ms, input logic [7:0] md, input logic [7:0] cnt);
        int pat;
        if (!ms[7])
            return {ms, 8'd0};
        if (int'(cnt) == AF - 1) begin
            pat = (int'(md[2:0]) + 1) % 8;
            return {1'b1, ms[6:3], 3'(pat), 8'd0};
        end
        return {1'b1, ms[6:3], md[2:0], 8'(int'(cnt) + 1)};
    endfunction

    // Reference: m_t counts clocks since reset release; mode follows the pin value
    // seen two clocks before each vblank edge.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_t    <= 0;
            m_mode <= 8'h00;
            m_cnt  <= 8'h00;
            for (int i = 0; i < 4; i++) hist[i] <= 8'h00;
        end else begin
            m_t <= m_t + 1;
            hist[m_t % 4] <= mode_in;
            if (is_vbl_edge(m_t + 1))
                {m_mode, m_cnt} <= next_mode(hist[(m_t + 2) % 4], m_mode, m_cnt);
        end
    end

    always @(negedge clk) begin : cmp
        int hp, vp;
        if (cmp_en) begin
            hp = m_t % HT;
            vp = (m_t / HT) % VT;
            chk("hpos", 32'(hpos), hp);
            chk("vpos", 32'(vpos), vp);
            chk("hsync", 32'(hsync), (hp >= HV + HF && hp < HV + HF + HS) ? 0 : 1);
            chk("vsync", 32'(vsync), (vp >= VV + VF && vp < VV + VF + VS) ? 0 : 1);
            chk("hblank", 32'(hblank), (hp >= HV) ? 1 : 0);
            chk("vblank", 32'(vblank), (vp >= VV) ? 1 : 0);
            chk("visible", 32'(visible), (hp < HV && vp < VV) ? 1 : 0);
            chk("line_start", 32'(line_start), (hp == 0) ? 1 : 0);
            chk("frame_start", 32'(frame_start), (hp == 0 && vp == 0) ? 1 : 0);
            chk("frame", 32'(frame), (m_t / FT) % 256);
            chk("mode", 32'(mode), 32'(m_mode));
        end
    end

    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        #2 reset = 1'b0;
    endtask

    task automatic run_to(input int tt);
        int g = 0;
        while (m_t < tt && g < 30000) begin
            @(negedge clk);
            g++;
        end
        chk("run_to", m_t, tt);
    endtask

    initial begin
        int vis;
        #1 reset = 1'b1;
        cmp_en = 1'b1;
        @(negedge clk);
        chk("rst_hsync", 32'(hsync), 1);
        chk("rst_vsync", 32'(vsync), 1);
        chk("rst_visible", 32'(visible), 1);
        chk("rst_frame_start", 32'(frame_start), 1);
        chk("rst_mode", 32'(mode), 0);
        #2 reset = 1'b0;

        // raster, blanking and deferred manual mode change
        vis = 0;
        for (int k = 1; k <= 160; k++) begin
            @(negedge clk);
            if (m_t >= 1 && m_t <= FT) vis += int'(visible);
            if (m_t == 5) mode_in = 8'h05;
            if (m_t == 60) mode_in = 8'h06;
            case (m_t)
                10:  chk("hsync_at10", 32'(hsync), 0);
                12:  chk("hsync_at12", 32'(hsync), 1);
                69:  chk("vsync_at69", 32'(vsync), 1);
                70:  chk("vsync_at70", 32'(vsync), 0);
                83:  chk("vsync_at83", 32'(vsync), 0);
                84:  chk("vsync_at84", 32'(vsync), 1);
                98:  begin
                    chk("frame_at98", 32'(frame), 1);
                    chk("fstart_at98", 32'(frame_start), 1);
                end
                55:  chk("mode_at55", 32'(mode), 32'h00);
                56:  chk("mode_at56", 32'(mode), 32'h05);
                153: chk("mode_at153", 32'(mode), 32'h05);
                154: begin
                    chk("mode_at154", 32'(mode), 32'h06);
                    chk("model_mode154", 32'(m_mode), 32'h06);
                end
                default: ;
            endcase
        end
        chk("visible_per_frame", vis, 32);

        // auto cycling from pattern 5, then with mode_in[6:3] changed
        mode_in = 8'h05;
        do_reset();
        for (int k = 1; k <= 700; k++) begin
            @(negedge clk);
            if (m_t == 60) mode_in = 8'h80;
            if (m_t == 400) mode_in = 8'hA8;
            case (m_t)
                56:  chk("auto_56", 32'(mode), 32'h05);
                154: chk("auto_154", 32'(mode), 32'h85);
                252: chk("auto_252", 32'(mode), 32'h86);
                350: chk("auto_350", 32'(mode), 32'h86);
                448: chk("auto_448", 32'(mode), 32'hAF);
                546: chk("auto_546", 32'(mode), 32'hAF);
                643: chk("auto_643", 32'(mode), 32'hAF);
                644: begin
                    chk("auto_644", 32'(mode), 32'hA8);
                    chk("model_auto644", 32'(m_mode), 32'hA8);
                end
                default: ;
            endcase
        end

        // asynchronous reset in the middle of vsync
        mode_in = 8'h05;
        do_reset();
        run_to(FT + 5 * HT + 9);
        chk("pre_hpos", 32'(hpos), 9);
        chk("pre_vpos", 32'(vpos), 5);
        chk("pre_vsync", 32'(vsync), 0);
        chk("pre_mode", 32'(mode), 32'h05);
        #2 reset = 1'b1;
        #1;
        chk("mid_hsync", 32'(hsync), 1);
        chk("mid_vsync", 32'(vsync), 1);
        chk("mid_mode", 32'(mode), 0);
        chk("mid_frame", 32'(frame), 0);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("rel_line_start", 32'(line_start), 1);
        chk("rel_frame_start", 32'(frame_start), 1);
        chk("rel_hpos", 32'(hpos), 0);
        @(negedge clk);
        chk("rel_hpos1", 32'(hpos), 1);
        chk("rel_vpos1", 32'(vpos), 0);

        // frame counter wrap
        mode_in = 8'h03;
        do_reset();
        run_to(255 * FT);
        chk("wrap_frame255", 32'(frame), 255);
        chk("wrap_mode255", 32'(mode), 32'h03);
        run_to(256 * FT);
        chk("wrap_frame0", 32'(frame), 0);
        chk("wrap_fstart", 32'(frame_start), 1);
        chk("wrap_mode0", 32'(mode), 32'h03);
        @(negedge clk);

        cmp_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
